// File: rtl/tm1638_driver.sv
// TM1638 LED&KEY refresh engine: writes digits, LEDs and control each frame,
// then reads back the four key bytes and publishes the pressed-key map.
module tm1638_driver #(
    parameter int CLK_DIV = 25,
    parameter int GAP     = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] digits,
    input  logic [7:0]  leds,
    input  logic [2:0]  brightness,
    input  logic        display_on,
    output logic [7:0]  keys,
    output logic        keys_valid,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio_out,
    output logic        tm_dio_oe,
    input  logic        tm_dio_in
);
    localparam int MAXC = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(GAP - 1);

    typedef enum logic [2:0] {
        GAP_WAIT,
        CMD_MODE,
        CMD_ADDR,
        CMD_CTRL,
        CMD_READ,
        READ_WAIT,
        READ_BYTES
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          setup;
    logic          hi;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [4:0]    byte_cnt;
    logic [4:0]    byte_nxt;
    logic [4:0]    last_byte;
    logic          last_bit;
    logic [3:0]    addr_idx;
    logic [7:0]    tx_byte;
    logic [63:0]   dig_q;
    logic [7:0]    led_q;
    logic [7:0]    ctrl_q;
    logic [7:0]    key_buf;
    logic          dio_s1;
    logic          dio_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dio_s1 <= 1'b1;
            dio_s2 <= 1'b1;
        end else begin
            dio_s1 <= tm_dio_in;
            dio_s2 <= dio_s1;
        end
    end

    // Position of the bit that the next tm_clk fall will present.
    always_comb begin
        bit_nxt  = bit_cnt + 3'd1;
        byte_nxt = byte_cnt;
        if (setup) begin
            bit_nxt  = 3'd0;
            byte_nxt = 5'd0;
        end else if (bit_cnt == 3'd7) begin
            byte_nxt = byte_cnt + 5'd1;
        end
    end

    assign addr_idx = byte_nxt[3:0] - 4'd1;

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            CMD_MODE: tx_byte = 8'h40;
            CMD_ADDR: begin
                if (byte_nxt == 5'd0)
                    tx_byte = 8'hC0;
                else if (!addr_idx[0])
                    tx_byte = dig_q[{addr_idx[3:1], 3'b000} +: 8];
                else
                    tx_byte = {7'b0, led_q[addr_idx[3:1]]};
            end
            CMD_CTRL: tx_byte = ctrl_q;
            CMD_READ: tx_byte = 8'h42;
            default:  tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        last_byte = 5'd0;
        case (state)
            CMD_ADDR:   last_byte = 5'd16;
            READ_BYTES: last_byte = 5'd3;
            default:    last_byte = 5'd0;
        endcase
    end

    assign last_bit = (bit_cnt == 3'd7) && (byte_cnt == last_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GAP_WAIT;
            nxt        <= CMD_MODE;
            cnt        <= '0;
            setup      <= 1'b0;
            hi         <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 5'd0;
            dig_q      <= '0;
            led_q      <= '0;
            ctrl_q     <= '0;
            key_buf    <= '0;
            keys       <= '0;
            keys_valid <= 1'b0;
            tm_stb     <= 1'b1;
            tm_clk     <= 1'b1;
            tm_dio_out <= 1'b1;
            tm_dio_oe  <= 1'b0;
        end else begin
            keys_valid <= 1'b0;
            cnt        <= cnt + CW'(1);
            case (state)
                GAP_WAIT: begin
                    if (cnt == GAP_END) begin
                        cnt       <= '0;
                        state     <= nxt;
                        setup     <= 1'b1;
                        tm_stb    <= 1'b0;
                        tm_dio_oe <= 1'b1;
                        if (nxt == CMD_MODE) begin
                            dig_q  <= digits;
                            led_q  <= leds;
                            ctrl_q <= {4'b1000, display_on, brightness};
                        end
                    end
                end
                CMD_MODE, CMD_ADDR, CMD_CTRL, CMD_READ: begin
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        if (hi && last_bit) begin
                            hi         <= 1'b0;
                            bit_cnt    <= 3'd0;
                            byte_cnt   <= 5'd0;
                            tm_dio_oe  <= 1'b0;
                            tm_dio_out <= 1'b1;
                            // The read command keeps STB low into the turnaround.
                            if (state == CMD_READ) begin
                                state <= READ_WAIT;
                            end else begin
                                tm_stb <= 1'b1;
                                state  <= GAP_WAIT;
                                case (state)
                                    CMD_MODE: nxt <= CMD_ADDR;
                                    CMD_ADDR: nxt <= CMD_CTRL;
                                    default:  nxt <= CMD_READ;
                                endcase
                            end
                        end else if (hi || setup) begin
                            setup      <= 1'b0;
                            hi         <= 1'b0;
                            tm_clk     <= 1'b0;
                            bit_cnt    <= bit_nxt;
                            byte_cnt   <= byte_nxt;
                            tm_dio_out <= tx_byte[bit_nxt];
                        end else begin
                            hi     <= 1'b1;
                            tm_clk <= 1'b1;
                        end
                    end
                end
                READ_WAIT: begin
                    if (cnt == GAP_END) begin
                        cnt    <= '0;
                        state  <= READ_BYTES;
                        hi     <= 1'b0;
                        tm_clk <= 1'b0;
                    end
                end
                READ_BYTES: begin
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        if (!hi) begin
                            hi     <= 1'b1;
                            tm_clk <= 1'b1;
                        end else begin
                            if (bit_cnt == 3'd0)
                                key_buf[{1'b0, byte_cnt[1:0]}] <= dio_s2;
                            if (bit_cnt == 3'd4)
                                key_buf[{1'b1, byte_cnt[1:0]}] <= dio_s2;
                            hi <= 1'b0;
                            if (last_bit) begin
                                bit_cnt    <= 3'd0;
                                byte_cnt   <= 5'd0;
                                tm_stb     <= 1'b1;
                                keys       <= key_buf;
                                keys_valid <= 1'b1;
                                state      <= GAP_WAIT;
                                nxt        <= CMD_MODE;
                            end else begin
                                tm_clk   <= 1'b0;
                                bit_cnt  <= bit_nxt;
                                byte_cnt <= byte_nxt;
                            end
                        end
                    end
                end
                default: state <= GAP_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_tm1638_driver.sv
// Bench for tm1638_driver: frame-position waveform model, TM1638 bus
// decoder and key-byte responder, with randomized inputs and resets.
module tb_tm1638_driver;
    localparam int C   = 2;
    localparam int G   = 4;
    localparam int B   = 16 * C;
    localparam int L   = 5 * G + 4 * C + 24 * B;
    localparam int RD0 = L - 4 * B;
    localparam int W2  = 2 * G + C + B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] digits;
    logic [7:0]  leds;
    logic [2:0]  brightness;
    logic        display_on;
    logic [7:0]  keys;
    logic        keys_valid;
    logic        tm_stb;
    logic        tm_clk;
    logic        tm_dio_out;
    logic        tm_dio_oe;
    logic        tm_dio_in;
    logic [3:0]  bus;

    tm1638_driver #(.CLK_DIV(C), .GAP(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .leds       (leds),
        .brightness (brightness),
        .display_on (display_on),
        .keys       (keys),
        .keys_valid (keys_valid),
        .tm_stb     (tm_stb),
        .tm_clk     (tm_clk),
        .tm_dio_out (tm_dio_out),
        .tm_dio_oe  (tm_dio_oe),
        .tm_dio_in  (tm_dio_in)
    );

    always #5 clk = ~clk;

    assign bus = {tm_stb, tm_clk, tm_dio_out, tm_dio_oe};

    int         checks = 0;
    int         errors = 0;
    int         t = 0;
    bit         done_prev = 1'b0;
    bit         force_rd = 1'b0;
    logic [7:0] fb [20];
    logic [7:0] rdb [4];
    logic [7:0] frc [4];
    logic [7:0] ek = 8'h00;
    logic [7:0] pend = 8'h00;
    logic [7:0] acc = 8'h00;
    int         nbit = 0;
    int         rbi;
    int         rd_clks = 0;
    logic       pclk = 1'b1;
    logic [7:0] rx_q [$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected {stb, clk, dio_out, oe} at cycle tt of a frame.
    function automatic logic [3:0] exp_bus(input int tt);
        int p;
        int base;
        int nb;
        int bi;
        p    = tt;
        base = 0;
        for (int w = 0; w < 4; w++) begin
            nb = (w == 1) ? 17 : 1;
            if (p < G) return 4'b1110;
            p -= G;
            if (p < C) return 4'b0111;
            p -= C;
            if (p < nb * B) begin
                bi = p / (2 * C);
                return {1'b0, ((p % (2 * C)) >= C), fb[base + bi / 8][bi % 8], 1'b1};
            end
            p -= nb * B;
            base += nb;
        end
        if (p < G) return 4'b0110;
        p -= G;
        return {1'b0, ((p % (2 * C)) >= C), 1'b1, 1'b0};
    endfunction

    function automatic logic [7:0] key_map();
        logic [7:0] k;
        k = 8'h00;
        for (int i = 0; i < 4; i++) begin
            k[i]     = rdb[i][0];
            k[i + 4] = rdb[i][4];
        end
        return k;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_bus", bus, 4'b1110);
            check("rst_keys", {keys_valid, keys}, 9'h000);
            t         = 0;
            done_prev = 1'b0;
            ek        = 8'h00;
            nbit      = 0;
            pclk      = 1'b1;
            rd_clks   = 0;
            rx_q.delete();
            tm_dio_in = 1'b1;
        end else begin
            if (t == 0 && done_prev) begin
                ek = pend;
                check("read_clocks", rd_clks, 32);
                rd_clks = 0;
            end
            check($sformatf("bus t=%0d", t), bus, exp_bus(t));
            check($sformatf("keys t=%0d", t), {keys_valid, keys},
                  {(t == 0) && done_prev, ek});
            if (t == 0) done_prev = 1'b0;
            if (!tm_stb && tm_clk && !pclk) begin
                if (tm_dio_oe) begin
                    acc[nbit] = tm_dio_out;
                    nbit++;
                    if (nbit == 8) begin
                        rx_q.push_back(acc);
                        nbit = 0;
                    end
                end else begin
                    rd_clks++;
                end
            end
            pclk = tm_clk;
            if (t == G - 1) begin
                fb[0] = 8'h40;
                fb[1] = 8'hC0;
                for (int i = 0; i < 8; i++) begin
                    fb[2 + 2 * i] = digits[8 * i +: 8];
                    fb[3 + 2 * i] = {7'b0, leds[i]};
                end
                fb[18] = 8'h80 | {4'b0, display_on, brightness};
                fb[19] = 8'h42;
                for (int i = 0; i < 4; i++)
                    rdb[i] = force_rd ? frc[i] : 8'($urandom);
            end
            if (t >= RD0) begin
                rbi = (t - RD0) / (2 * C);
                tm_dio_in = rdb[rbi / 8][rbi % 8];
            end else begin
                tm_dio_in = 1'b1;
            end
            if (t == L - 1) begin
                done_prev = 1'b1;
                pend      = key_map();
                t         = 0;
            end else begin
                t = t + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!keys_valid && n < 3 * L);
        check("keys_valid_seen", keys_valid, 1'b1);
    endtask

    task automatic wait_t(input int target);
        int n;
        n = 0;
        while (t != target && n < 2 * L) begin
            step();
            n++;
        end
        if (t != target) begin
            checks++;
            errors++;
            $display("FAIL wait_t: at %0d want %0d", t, target);
        end
    endtask

    initial begin
        int n;
        logic [7:0] exp1 [20];
        exp1 = '{8'h40, 8'hC0, 8'hEF, 8'h01, 8'hCD, 8'h00, 8'hAB, 8'h01,
                 8'h89, 8'h00, 8'h67, 8'h00, 8'h45, 8'h01, 8'h23, 8'h00,
                 8'h01, 8'h01, 8'h8D, 8'h42};
        digits     = 64'h0123_4567_89AB_CDEF;
        leds       = 8'b1010_0101;
        brightness = 3'd5;
        display_on = 1'b1;
        frc        = '{8'h01, 8'h10, 8'h00, 8'h11};
        force_rd   = 1'b1;
        repeat (3) step();
        check("rst_init", {bus, keys_valid, keys}, 13'b1110_0_0000_0000);
        rst_n = 1'b1;

        wait_t(G);
        check("first_stb_oe", {tm_stb, tm_dio_oe}, 2'b01);
        wait_t(W2 + C + 5 * B);
        digits     = 64'hFEDC_BA98_7654_3210;
        display_on = 1'b0;
        force_rd   = 1'b0;
        wait_valid(n);
        check("keys_f1", keys, 8'b1010_1001);
        check("nbytes_f1", rx_q.size(), 20);
        for (int i = 0; i < 20; i++)
            check($sformatf("f1_byte%0d", i), rx_q[i], exp1[i]);

        wait_valid(n);
        check("frame_len", n, 796);
        check("f2_mode", rx_q[20], 8'h40);
        check("f2_dig0", rx_q[22], 8'h10);
        check("f2_led0", rx_q[23], 8'h01);
        check("f2_dig1", rx_q[24], 8'h32);
        check("f2_ctrl", rx_q[38], 8'h85);

        for (int f = 0; f < 6; f++) begin
            if (f == 0) wait_t(G - 1);
            else if (f == 1) wait_t(G);
            else wait_t(int'($urandom_range(1, L - 2)));
            digits     = {$urandom, $urandom};
            leds       = 8'($urandom);
            brightness = 3'($urandom);
            display_on = 1'($urandom);
            wait_valid(n);
        end

        frc      = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        force_rd = 1'b1;
        wait_valid(n);
        check("keys_ff", keys, 8'hFF);
        wait_t(W2 + C + 8 * B + B / 2);
        rst_n = 1'b0;
        #1;
        check("rst_async", {bus, keys_valid, keys}, 13'b1110_0_0000_0000);
        repeat (3) step();
        rst_n = 1'b1;
        wait_valid(n);
        check("post_rst_len", n, 796);
        check("post_rst_nbytes", rx_q.size(), 20);
        check("post_rst_mode", rx_q[0], 8'h40);
        check("post_rst_addr", rx_q[1], 8'hC0);
        check("post_rst_read", rx_q[19], 8'h42);
        check("post_rst_keys", keys, 8'hFF);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
